max7219_frame_decoder: RTL and testbench



---
 rtl/max7219_frame_decoder.sv | 167 ++++++++++++++++
 tb/tb_max7219_frame_decoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/max7219_frame_decoder.sv
// Passive MAX7219 link listener: deserialises DIN/CLK/LOAD frames and keeps a
// decoded shadow of the eight digit registers plus the decode-mode register.
module max7219_frame_decoder #(
  parameter int CLK_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_din,
  input  logic        spi_load,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic [31:0] digit_hex,
  output logic [7:0]  digit_known,
  output logic [7:0]  digit_dp
);

  // Returns {known, nibble} for one digit byte under the given decode mode.
  function automatic logic [4:0] decode_digit(input logic code_b, input logic [7:0] data);
    logic [4:0] r;
    r = 5'h00;
    if (code_b) begin
      if (data[3:0] <= 4'd9) r = {1'b1, data[3:0]};
      else                   r = 5'h00;
    end else begin
      case (data[6:0])
        7'h7E:   r = 5'h10;
        7'h30:   r = 5'h11;
        7'h6D:   r = 5'h12;
        7'h79:   r = 5'h13;
        7'h33:   r = 5'h14;
        7'h5B:   r = 5'h15;
        7'h5F:   r = 5'h16;
        7'h70:   r = 5'h17;
        7'h7F:   r = 5'h18;
        7'h7B:   r = 5'h19;
        7'h77:   r = 5'h1A;
        7'h1F:   r = 5'h1B;
        7'h4E:   r = 5'h1C;
        7'h3D:   r = 5'h1D;
        7'h4F:   r = 5'h1E;
        7'h47:   r = 5'h1F;
        default: r = 5'h00;
      endcase
    end
    return r;
  endfunction

  logic [CLK_SYNC_STAGES-1:0] clk_sync_q, din_sync_q, load_sync_q;
  logic        clk_prev_q, load_prev_q;
  logic        clk_rise_q, load_rise_q, din_q;

  // D15..D12 never reach an output, so only the low 12 bits are kept.
  logic [11:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d, error_q, error_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  decode_q, decode_d;
  logic [31:0] hex_q, hex_d;
  logic [7:0]  known_q, known_d, dp_q, dp_d;
  logic [2:0]  idx_s;
  logic [4:0]  dec_s;

  // Input synchronisers and registered edge detection; din is delayed to stay aligned with the clock rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '0;
      din_sync_q  <= '0;
      load_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      load_prev_q <= 1'b0;
      clk_rise_q  <= 1'b0;
      load_rise_q <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[CLK_SYNC_STAGES-2:0], spi_clk};
      din_sync_q  <= {din_sync_q[CLK_SYNC_STAGES-2:0], spi_din};
      load_sync_q <= {load_sync_q[CLK_SYNC_STAGES-2:0], spi_load};
      clk_prev_q  <= clk_sync_q[CLK_SYNC_STAGES-1];
      load_prev_q <= load_sync_q[CLK_SYNC_STAGES-1];
      clk_rise_q  <= clk_sync_q[CLK_SYNC_STAGES-1] & ~clk_prev_q;
      load_rise_q <= load_sync_q[CLK_SYNC_STAGES-1] & ~load_prev_q;
      din_q       <= din_sync_q[CLK_SYNC_STAGES-1];
    end
  end

  // Frame assembly and shadow-register update; a LOAD rise takes priority over a clock rise.
  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    decode_d = decode_q;
    hex_d    = hex_q;
    known_d  = known_q;
    dp_d     = dp_q;
    idx_s    = 3'(shift_q[11:8] - 4'd1);
    dec_s    = decode_digit(decode_q[idx_s], shift_q[7:0]);
    if (load_rise_q) begin
      cnt_d   = 5'd0;
      shift_d = 12'h000;
      if (cnt_q == 5'd16) begin
        valid_d = 1'b1;
        addr_d  = shift_q[11:8];
        data_d  = shift_q[7:0];
        case (shift_q[11:8])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            hex_d[idx_s*4 +: 4] = dec_s[3:0];
            known_d[idx_s]      = dec_s[4];
            dp_d[idx_s]         = shift_q[7];
          end
          4'h9:    decode_d = shift_q[7:0];
          default: decode_d = decode_q;
        endcase
      end else begin
        error_d = 1'b1;
      end
    end else if (clk_rise_q) begin
      shift_d = {shift_q[10:0], din_q};
      if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
      else                cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 5'd0;
      shift_q  <= 12'h000;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      addr_q   <= 4'h0;
      data_q   <= 8'h00;
      decode_q <= 8'h00;
      hex_q    <= 32'h0;
      known_q  <= 8'h00;
      dp_q     <= 8'h00;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      decode_q <= decode_d;
      hex_q    <= hex_d;
      known_q  <= known_d;
      dp_q     <= dp_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign frame_addr  = addr_q;
  assign frame_data  = data_q;
  assign digit_hex   = hex_q;
  assign digit_known = known_q;
  assign digit_dp    = dp_q;

endmodule

// File: tb/tb_max7219_frame_decoder.sv
// Directed bench for max7219_frame_decoder: bit-bangs MAX7219 frames and checks
// pulses, latency and the shadow digit outputs against hand-computed values.
module tb_max7219_frame_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_din = 1'b0;
  logic        spi_load = 1'b0;
  logic        frame_valid, frame_error;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic [31:0] digit_hex;
  logic [7:0]  digit_known, digit_dp;

  int checks = 0;
  int errors = 0;

  max7219_frame_decoder #(.CLK_SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_din(spi_din), .spi_load(spi_load),
    .frame_valid(frame_valid), .frame_error(frame_error), .frame_addr(frame_addr),
    .frame_data(frame_data), .digit_hex(digit_hex), .digit_known(digit_known), .digit_dp(digit_dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      spi_din = v[i];
      repeat (3) @(negedge clk);
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  // Raise LOAD and watch eight cycles for pulses; lat is the cycle of the first pulse.
  task automatic do_load(output int vc, output int ec, output int lat, output int ov);
    vc = 0; ec = 0; lat = 0; ov = 0;
    @(negedge clk);
    spi_load = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (frame_valid) begin vc++; if (lat == 0) lat = i; end
      if (frame_error) begin ec++; if (lat == 0) lat = i; end
      if (frame_valid && frame_error) ov++;
    end
    spi_load = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input string tag, input logic [31:0] v, input int n, input bit good);
    int vc, ec, lat, ov;
    send_bits(v, n);
    do_load(vc, ec, lat, ov);
    check({tag, " valid_cnt"}, 32'(vc), good ? 32'd1 : 32'd0);
    check({tag, " error_cnt"}, 32'(ec), good ? 32'd0 : 32'd1);
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " overlap"}, 32'(ov), 32'd0);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] a, input logic [7:0] d,
                            input logic [31:0] h, input logic [7:0] k, input logic [7:0] p);
    check({tag, " addr"}, {28'h0, frame_addr}, {28'h0, a});
    check({tag, " data"}, {24'h0, frame_data}, {24'h0, d});
    check({tag, " hex"}, digit_hex, h);
    check({tag, " known"}, {24'h0, digit_known}, {24'h0, k});
    check({tag, " dp"}, {24'h0, digit_dp}, {24'h0, p});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outs("reset", 4'h0, 8'h00, 32'h0, 8'h00, 8'h00);
    check("reset valid", {31'h0, frame_valid}, 32'd0);
    check("reset error", {31'h0, frame_error}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    frame("f017E", 32'h017E, 16, 1'b1);
    check_outs("f017E", 4'h1, 8'h7E, 32'h0000_0000, 8'h01, 8'h00);

    frame("d1", 32'h0130, 16, 1'b1);
    frame("d2", 32'h026D, 16, 1'b1);
    frame("d3", 32'h0379, 16, 1'b1);
    frame("d4", 32'h0433, 16, 1'b1);
    frame("d5", 32'h05DB, 16, 1'b1);
    frame("d6", 32'h065F, 16, 1'b1);
    frame("d7", 32'h0770, 16, 1'b1);
    frame("d8", 32'h0847, 16, 1'b1);
    check_outs("all digits", 4'h8, 8'h47, 32'hF765_4321, 8'hFF, 8'h10);

    frame("decode all", 32'h09FF, 16, 1'b1);
    check_outs("no redecode", 4'h9, 8'hFF, 32'hF765_4321, 8'hFF, 8'h10);
    frame("codeb 5", 32'h0385, 16, 1'b1);
    check_outs("codeb 5", 4'h3, 8'h85, 32'hF765_4521, 8'hFF, 8'h14);
    frame("codeb B", 32'h030B, 16, 1'b1);
    check_outs("codeb B", 4'h3, 8'h0B, 32'hF765_4021, 8'hFB, 8'h10);

    frame("short15", 32'h0177, 15, 1'b0);
    check_outs("short15", 4'h3, 8'h0B, 32'hF765_4021, 8'hFB, 8'h10);
    frame("long17", 32'h1_0177, 17, 1'b0);
    check_outs("long17", 4'h3, 8'h0B, 32'hF765_4021, 8'hFB, 8'h10);

    frame("nodecode", 32'h0900, 16, 1'b1);
    check_outs("nodecode", 4'h9, 8'h00, 32'hF765_4021, 8'hFB, 8'h10);
    frame("g only", 32'h0101, 16, 1'b1);
    check_outs("g only", 4'h1, 8'h01, 32'hF765_4020, 8'hFA, 8'h10);
    frame("shutdown", 32'h0C01, 16, 1'b1);
    check_outs("shutdown", 4'hC, 8'h01, 32'hF765_4020, 8'hFA, 8'h10);

    send_bits(32'h01, 8);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("midreset", 4'h0, 8'h00, 32'h0, 8'h00, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame("after reset", 32'h7E, 8, 1'b0);
    check_outs("after reset", 4'h0, 8'h00, 32'h0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
